mtc_pkt_decoder: RTL and testbench

- Receive-side counterpart of the MTC packet formatter.
- Accepts 128-bit MTC-to-SL packets over a valid/ready interface and decodes the processing-flag and reserved fields.
- Classifies each packet and keeps saturating per-class statistics counters.
- Buffers decoded packets in a small first-word-fall-through FIFO for the downstream consumer.
- Used by the SL-side emulator and the MTC output monitor.

---
 rtl/mtc_pkt_decoder.sv | 160 ++++++++++++++++
 tb/tb_mtc_pkt_decoder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtc_pkt_decoder.sv
// Receive-side MTC-to-SL packet decoder: one-stage decode, saturating per-class statistics
// and a first-word-fall-through output FIFO whose space is reserved at accept time.
module mtc_pkt_decoder #(
   parameter int unsigned MTC_PKT_WIDTH = 128,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned CNT_WIDTH     = 16,
   parameter bit          DROP_EMPTY    = 1'b0
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic [MTC_PKT_WIDTH-1:0] mtc_in,
   input  logic                     mtc_in_valid,
   output logic                     mtc_in_ready,
   output logic [MTC_PKT_WIDTH-1:0] pkt_out,
   output logic [3:0]               procflags_out,
   output logic                     pass_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     clear_counters,
   output logic [CNT_WIDTH-1:0]     cnt_pass,
   output logic [CNT_WIDTH-1:0]     cnt_below,
   output logic [CNT_WIDTH-1:0]     cnt_board,
   output logic [CNT_WIDTH-1:0]     cnt_fail,
   output logic [CNT_WIDTH-1:0]     cnt_empty,
   output logic [CNT_WIDTH-1:0]     cnt_err,
   output logic                     err_sticky
);

   localparam int unsigned MTC2SL_MDT_PROCFLAGS_LSB = 0;
   localparam int unsigned MTC2SL_MDT_PROCFLAGS_MSB = 3;
   localparam int unsigned MTC2SL_M_RESERVED_LSB    = 4;
   localparam int unsigned MTC2SL_M_RESERVED_MSB    = 11;

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OccW = CntW + 1;

   localparam int unsigned IdxPass  = 0;
   localparam int unsigned IdxBelow = 1;
   localparam int unsigned IdxBoard = 2;
   localparam int unsigned IdxFail  = 3;
   localparam int unsigned IdxEmpty = 4;
   localparam int unsigned IdxErr   = 5;
   localparam int unsigned NumCnt   = 6;

   logic                     stage_valid_q, stage_valid_d;
   logic [MTC_PKT_WIDTH-1:0] stage_pkt_q, stage_pkt_d;
   logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]          count_q, count_d;
   logic [MTC_PKT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [CNT_WIDTH-1:0]     cnt_q [NumCnt];
   logic [CNT_WIDTH-1:0]     cnt_d [NumCnt];
   logic                     err_sticky_q, err_sticky_d;

   logic [OccW-1:0]  occupancy;
   logic             accept;
   logic             push;
   logic             pop;
   logic [3:0]       stage_pf;
   logic             reserved_err;
   logic             illegal_pf;
   logic [NumCnt-1:0] inc;

   function automatic logic [CNT_WIDTH-1:0] sat_next(input logic [CNT_WIDTH-1:0] cur,
                                                     input logic                 do_inc,
                                                     input logic                 clr);
      if (clr) return '0;
      if (do_inc && (cur != {CNT_WIDTH{1'b1}})) return cur + CNT_WIDTH'(1);
      return cur;
   endfunction

   // Stage occupancy counts as FIFO occupancy so the decode stage can always drain.
   assign occupancy    = OccW'(count_q) + OccW'(stage_valid_q);
   assign mtc_in_ready = !rst && (occupancy < OccW'(FIFO_DEPTH));
   assign accept       = mtc_in_valid && mtc_in_ready;

   assign stage_pf     = stage_pkt_q[MTC2SL_MDT_PROCFLAGS_MSB:MTC2SL_MDT_PROCFLAGS_LSB];
   assign reserved_err = |stage_pkt_q[MTC2SL_M_RESERVED_MSB:MTC2SL_M_RESERVED_LSB];
   assign push         = stage_valid_q && !(DROP_EMPTY && (stage_pf == 4'd0));

   assign out_valid     = (count_q != '0);
   assign pop           = out_valid && out_ready;
   assign pkt_out       = out_valid ? mem_q[rd_ptr_q] : '0;
   assign procflags_out = pkt_out[MTC2SL_MDT_PROCFLAGS_MSB:MTC2SL_MDT_PROCFLAGS_LSB];
   assign pass_out      = (procflags_out == 4'd1);

   always_comb begin
      inc        = '0;
      illegal_pf = 1'b0;
      case (stage_pf)
         4'd0:                   inc[IdxEmpty] = 1'b1;
         4'd1:                   inc[IdxPass]  = 1'b1;
         4'd2:                   inc[IdxBelow] = 1'b1;
         4'd3:                   inc[IdxBoard] = 1'b1;
         4'd4, 4'd5, 4'd6, 4'd15: inc[IdxFail] = 1'b1;
         default:                illegal_pf    = 1'b1;
      endcase
      // A packet with both faults still bumps cnt_err only once.
      inc[IdxErr] = illegal_pf | reserved_err;
      inc         = inc & {NumCnt{stage_valid_q}};
   end

   always_comb begin
      stage_valid_d = accept;
      stage_pkt_d   = accept ? mtc_in : stage_pkt_q;
      wr_ptr_d      = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d      = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d       = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      for (int i = 0; i < NumCnt; i++) begin
         cnt_d[i] = sat_next(cnt_q[i], inc[i], clear_counters);
      end
      err_sticky_d = clear_counters ? 1'b0 : (err_sticky_q | inc[IdxErr]);
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         stage_valid_q <= 1'b0;
         stage_pkt_q   <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         err_sticky_q  <= 1'b0;
         for (int i = 0; i < NumCnt; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stage_valid_q <= stage_valid_d;
         stage_pkt_q   <= stage_pkt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         err_sticky_q  <= err_sticky_d;
         for (int i = 0; i < NumCnt; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Storage needs no reset: pkt_out is masked whenever the FIFO is empty.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= stage_pkt_q;
      end
   end

   assign cnt_pass   = cnt_q[IdxPass];
   assign cnt_below  = cnt_q[IdxBelow];
   assign cnt_board  = cnt_q[IdxBoard];
   assign cnt_fail   = cnt_q[IdxFail];
   assign cnt_empty  = cnt_q[IdxEmpty];
   assign cnt_err    = cnt_q[IdxErr];
   assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mtc_pkt_decoder.sv
// Bench for mtc_pkt_decoder: three instances (default, DROP_EMPTY=1, CNT_WIDTH=4) share one
// stimulus stream and are checked every cycle against a queue-based model plus literal values.
module tb_mtc_pkt_decoder;

   logic         clock = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] mtc_in = '0;
   logic         mtc_in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         clear_counters = 1'b0;

   logic         rdy [3];
   logic         ov  [3];
   logic         ps  [3];
   logic         es  [3];
   logic [127:0] pk  [3];
   logic [3:0]   pf  [3];
   logic [15:0]  cnt [3][6];
   logic [3:0]   s_cnt [6];

   int n_pass = 0;
   int n_total = 0;

   // Model state, per instance
   bit [127:0] mq [3][4];
   int         mn [3];
   bit         sv [3];
   bit [127:0] sp [3];
   int         mc [3][6];
   bit         mst [3];
   bit         macc [3];
   bit         armed = 1'b0;

   bit [127:0] seen [3][32];
   int         seen_n [3];
   logic [127:0] tx [24];
   int         tx_n;

   always #5 clock = ~clock;

   mtc_pkt_decoder u_dut0 (
      .clock(clock), .rst(rst), .mtc_in(mtc_in), .mtc_in_valid(mtc_in_valid),
      .mtc_in_ready(rdy[0]), .pkt_out(pk[0]), .procflags_out(pf[0]), .pass_out(ps[0]),
      .out_valid(ov[0]), .out_ready(out_ready), .clear_counters(clear_counters),
      .cnt_pass(cnt[0][0]), .cnt_below(cnt[0][1]), .cnt_board(cnt[0][2]), .cnt_fail(cnt[0][3]),
      .cnt_empty(cnt[0][4]), .cnt_err(cnt[0][5]), .err_sticky(es[0])
   );

   mtc_pkt_decoder #(.DROP_EMPTY(1'b1)) u_dut1 (
      .clock(clock), .rst(rst), .mtc_in(mtc_in), .mtc_in_valid(mtc_in_valid),
      .mtc_in_ready(rdy[1]), .pkt_out(pk[1]), .procflags_out(pf[1]), .pass_out(ps[1]),
      .out_valid(ov[1]), .out_ready(out_ready), .clear_counters(clear_counters),
      .cnt_pass(cnt[1][0]), .cnt_below(cnt[1][1]), .cnt_board(cnt[1][2]), .cnt_fail(cnt[1][3]),
      .cnt_empty(cnt[1][4]), .cnt_err(cnt[1][5]), .err_sticky(es[1])
   );

   mtc_pkt_decoder #(.CNT_WIDTH(4)) u_dut2 (
      .clock(clock), .rst(rst), .mtc_in(mtc_in), .mtc_in_valid(mtc_in_valid),
      .mtc_in_ready(rdy[2]), .pkt_out(pk[2]), .procflags_out(pf[2]), .pass_out(ps[2]),
      .out_valid(ov[2]), .out_ready(out_ready), .clear_counters(clear_counters),
      .cnt_pass(s_cnt[0]), .cnt_below(s_cnt[1]), .cnt_board(s_cnt[2]), .cnt_fail(s_cnt[3]),
      .cnt_empty(s_cnt[4]), .cnt_err(s_cnt[5]), .err_sticky(es[2])
   );

   for (genvar g = 0; g < 6; g++) begin : g_ext
      assign cnt[2][g] = {12'd0, s_cnt[g]};
   end

   function automatic bit is_drop(int i);
      return i == 1;
   endfunction

   function automatic int cmax(int i);
      return (i == 2) ? 15 : 65535;
   endfunction

   function automatic logic [127:0] mk(bit [7:0] rsv, bit [3:0] flags, int tag);
      return {32'(tag), 52'h0, 32'hDEAD_0000 | 32'(tag), rsv, flags};
   endfunction

   task automatic check(input string name, input int inst, input logic [127:0] act,
                        input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %0h, required %0h", name, inst, act, exp);
   endtask

   task automatic bump(int i, int k);
      if (mc[i][k] < cmax(i)) mc[i][k]++;
   endtask

   // One clock edge of the specified behaviour, for instance i
   task automatic model_step(int i);
      bit [3:0] flags;
      int       cls;
      bit       err;
      if (rst) begin
         mn[i] = 0; sv[i] = 0; sp[i] = '0; mst[i] = 0; macc[i] = 0;
         for (int k = 0; k < 6; k++) mc[i][k] = 0;
         return;
      end
      macc[i] = mtc_in_valid && ((mn[i] + int'(sv[i])) < 4);
      if (out_ready && mn[i] > 0) begin
         for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
         mn[i]--;
      end
      if (sv[i]) begin
         flags = sp[i][3:0];
         cls = -1;
         if (flags == 0) cls = 4;
         else if (flags == 1) cls = 0;
         else if (flags == 2) cls = 1;
         else if (flags == 3) cls = 2;
         else if (flags inside {4, 5, 6, 15}) cls = 3;
         err = (cls < 0) || (sp[i][11:4] != 0);
         if (cls >= 0) bump(i, cls);
         if (err) begin bump(i, 5); mst[i] = 1; end
         if (!(is_drop(i) && flags == 0)) begin
            if (mn[i] >= 4) check("fifo_overflow", i, 1, 0);
            else begin mq[i][mn[i]] = sp[i]; mn[i]++; end
         end
      end
      if (clear_counters) begin
         for (int k = 0; k < 6; k++) mc[i][k] = 0;
         mst[i] = 0;
      end
      sv[i] = macc[i];
      if (macc[i]) sp[i] = mtc_in;
   endtask

   initial forever begin
      @(posedge clock);
      for (int i = 0; i < 3; i++) model_step(i);
      if (rst) armed = 1'b1;
   end

   // Compare process: every cycle, every instance, every output
   initial forever begin
      logic [127:0] e_pk;
      @(negedge clock);
      if (armed) begin
         for (int i = 0; i < 3; i++) begin
            e_pk = (mn[i] > 0) ? mq[i][0] : '0;
            check("mtc_in_ready", i, rdy[i], !rst && ((mn[i] + int'(sv[i])) < 4));
            check("out_valid", i, ov[i], mn[i] > 0);
            check("pkt_out", i, pk[i], e_pk);
            check("procflags_out", i, pf[i], e_pk[3:0]);
            check("pass_out", i, ps[i], e_pk[3:0] == 4'd1);
            check("cnt_pass", i, cnt[i][0], mc[i][0]);
            check("cnt_below", i, cnt[i][1], mc[i][1]);
            check("cnt_board", i, cnt[i][2], mc[i][2]);
            check("cnt_fail", i, cnt[i][3], mc[i][3]);
            check("cnt_empty", i, cnt[i][4], mc[i][4]);
            check("cnt_err", i, cnt[i][5], mc[i][5]);
            check("err_sticky", i, es[i], mst[i]);
            if (ov[i] === 1'b1 && out_ready && seen_n[i] < 32) begin
               seen[i][seen_n[i]] = pk[i];
               seen_n[i]++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic send_all();
      int k = 0;
      int guard = 0;
      while (k < tx_n && guard < 200) begin
         mtc_in = tx[k];
         mtc_in_valid = 1'b1;
         tick();
         if (macc[0]) k++;
         guard++;
      end
      mtc_in_valid = 1'b0;
      if (k < tx_n) check("send_timeout", 0, k, tx_n);
   endtask

   task automatic clr();
      clear_counters = 1'b1;
      tick();
      clear_counters = 1'b0;
      for (int i = 0; i < 3; i++) seen_n[i] = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) seen_n[i] = 0;
      repeat (2) tick();
      rst = 1'b0;

      // Single pass packet: visible two edges after accept
      out_ready = 1'b1;
      mtc_in = mk(8'h00, 4'd1, 1);
      mtc_in_valid = 1'b1;
      tick();
      mtc_in_valid = 1'b0;
      @(negedge clock);
      check("t1_valid_early", 0, ov[0], 0);
      tick();
      @(negedge clock);
      check("t1_valid", 0, ov[0], 1);
      check("t1_pass_out", 0, ps[0], 1);
      check("t1_pkt", 0, pk[0], mk(8'h00, 4'd1, 1));
      check("t1_cnt_pass", 0, cnt[0][0], 1);
      check("t1_model_pass", 0, mc[0][0], 1);
      check("t1_cnt_err", 0, cnt[0][5], 0);
      check("t1_sticky", 0, es[0], 0);
      repeat (3) tick();

      // Backpressure: 6 packets, consumer stalled
      clr();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) tx[k] = mk(8'h00, 4'd1, 10 + k);
      tx_n = 4;
      send_all();
      @(negedge clock);
      check("bp_ready_low", 0, rdy[0], 0);
      mtc_in = mk(8'h00, 4'd1, 14);
      mtc_in_valid = 1'b1;
      repeat (3) tick();
      mtc_in_valid = 1'b0;
      check("bp_model_full", 0, mn[0], 4);
      check("bp_head", 0, pk[0], mk(8'h00, 4'd1, 10));
      out_ready = 1'b1;
      tx[0] = mk(8'h00, 4'd1, 14);
      tx[1] = mk(8'h00, 4'd1, 15);
      tx_n = 2;
      send_all();
      repeat (10) tick();
      check("bp_out_count", 0, seen_n[0], 6);
      for (int k = 0; k < 6; k++) check("bp_order", 0, seen[0][k], mk(8'h00, 4'd1, 10 + k));

      // Mixed classes and a reserved-field error
      clr();
      tx[0] = mk(8'h00, 4'd2, 20);
      tx[1] = mk(8'h00, 4'd3, 21);
      tx[2] = mk(8'h00, 4'd4, 22);
      tx[3] = mk(8'h00, 4'd15, 23);
      tx[4] = mk(8'h00, 4'd9, 24);
      tx[5] = mk(8'h01, 4'd1, 25);
      tx_n = 6;
      send_all();
      repeat (8) tick();
      for (int i = 0; i < 3; i++) begin
         check("mix_below", i, cnt[i][1], 1);
         check("mix_board", i, cnt[i][2], 1);
         check("mix_fail", i, cnt[i][3], 2);
         check("mix_pass", i, cnt[i][0], 1);
         check("mix_err", i, cnt[i][5], 2);
         check("mix_sticky", i, es[i], 1);
         check("mix_out_count", i, seen_n[i], 6);
      end
      check("mix_model_err", 0, mc[0][5], 2);

      // Alternate empty/pass: DROP_EMPTY instance outputs only the passes
      clr();
      for (int k = 0; k < 8; k++) tx[k] = mk(8'h00, 4'(k % 2), 40 + k);
      tx_n = 8;
      send_all();
      repeat (8) tick();
      check("drop_empty_cnt", 1, cnt[1][4], 4);
      check("drop_pass_cnt", 1, cnt[1][0], 4);
      check("drop_out_count", 1, seen_n[1], 4);
      for (int k = 0; k < 4; k++) check("drop_order", 1, seen[1][k], mk(8'h00, 4'd1, 41 + 2 * k));
      check("keep_out_count", 0, seen_n[0], 8);
      check("keep_empty_cnt", 0, cnt[0][4], 4);

      // Saturation at 4 bits, then clear colliding with an increment and an error
      clr();
      for (int k = 0; k < 20; k++) tx[k] = mk(8'h00, 4'd1, 60 + k);
      tx_n = 20;
      send_all();
      repeat (6) tick();
      check("sat_cnt4", 2, cnt[2][0], 15);
      check("sat_model4", 2, mc[2][0], 15);
      check("sat_cnt16", 0, cnt[0][0], 20);
      mtc_in = mk(8'h01, 4'd1, 90);
      mtc_in_valid = 1'b1;
      tick();
      mtc_in_valid = 1'b0;
      clear_counters = 1'b1;
      tick();
      clear_counters = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         check("clr_wins_pass", i, cnt[i][0], 0);
         check("clr_wins_err", i, cnt[i][5], 0);
         check("clr_wins_sticky", i, es[i], 0);
      end
      repeat (4) tick();

      // Reset with 3 packets buffered and the stage occupied
      clr();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) tx[k] = mk(8'h00, 4'd1, 100 + k);
      tx_n = 4;
      send_all();
      check("rst_pre_fifo", 0, mn[0], 3);
      check("rst_pre_stage", 0, sv[0], 1);
      check("rst_pre_pass", 0, cnt[0][0], 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         check("rst_out_valid", i, ov[i], 0);
         check("rst_ready", i, rdy[i], 1);
         check("rst_cnt_pass", i, cnt[i][0], 0);
      end
      for (int i = 0; i < 3; i++) seen_n[i] = 0;
      out_ready = 1'b1;
      tx[0] = mk(8'h00, 4'd3, 120);
      tx_n = 1;
      send_all();
      repeat (4) tick();
      check("post_rst_board", 0, cnt[0][2], 1);
      check("post_rst_out_count", 0, seen_n[0], 1);
      check("post_rst_pkt", 0, seen[0][0], mk(8'h00, 4'd3, 120));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
